// File: rtl/fifo_afull.sv
// First-word fall-through FIFO over a register array, with an occupancy count and
// an almost-full flag so producers with long flow-control latency can throttle early.
module fifo_afull #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 5,
    parameter int DEPTH              = 32,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         FULL_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0]         AFULL_LEVEL = CW'(DEPTH - ALMOST_FULL_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;

    // Explicit wrap keeps non-power-of-two depths from indexing past DEPTH-1.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + ADDR_WIDTH'(1);
    endfunction

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_next = if_count;
        case ({push, pop})
            2'b10:   count_next = if_count + CW'(1);
            2'b01:   count_next = if_count - CW'(1);
            default: count_next = if_count;
        endcase
    end

    // Flags are registered from the next-state count so they line up with if_count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            if_count         <= '0;
            if_empty_n       <= 1'b0;
            if_full_n        <= 1'b1;
            if_almost_full_n <= 1'b1;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if_count         <= count_next;
            if_empty_n       <= (count_next != '0);
            if_full_n        <= (count_next != FULL_LEVEL);
            if_almost_full_n <= (count_next < AFULL_LEVEL);
        end
    end

    // Storage carries no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= if_din;
    end

    assign if_dout = mem[rd_ptr];
endmodule

// File: doc/fifo_afull.md
# fifo_afull

Parametrised first-word fall-through (FWFT) FIFO with a programmable almost-full margin and an occupancy count output. It extends the plain FWFT stream FIFO so that producers can start throttling before the FIFO is actually full. This matters where the producer's own pipeline latency means a flow-control decision arrives several cycles late, as on relay and inter-slot stream links. Storage is a register array, read combinationally at the head; non-power-of-two depths are supported.

## Interface
- DATA_WIDTH, 32, payload width in bits (>= 1)
- ADDR_WIDTH, 5, pointer width; must equal ceil(log2(DEPTH))
- DEPTH, 32, capacity in words (>= 2; non-power-of-two allowed)
- ALMOST_FULL_MARGIN, 2, number of free slots still available when if_almost_full_n deasserts (0 .. DEPTH-1)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- if_full_n  out  1  high when at least one slot is free
- if_almost_full_n  out  1  high when count < DEPTH - ALMOST_FULL_MARGIN
- if_write_ce  in  1  write-side clock enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_empty_n  out  1  high when head word is valid on if_dout
- if_read_ce  in  1  read-side clock enable
- if_read  in  1  read request (pop head)
- if_dout  out  DATA_WIDTH  head word (FWFT); undefined when if_empty_n=0
- if_count  out  ADDR_WIDTH+1  current occupancy, 0 .. DEPTH

## Operation
- Push condition: if_write & if_write_ce & if_full_n. When it holds, if_din is stored at wr_ptr and wr_ptr advances.
- Pop condition: if_read & if_read_ce & if_empty_n. When it holds, rd_ptr advances.
- Pushes while full and pops while empty are ignored silently: no state change, no error.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Do not use natural binary wrap unless DEPTH is a power of two.
- Count update (DEPTH is never exceeded and count never underflows):
  - push only: count+1
  - pop only: count-1
  - both, or neither: unchanged
- Simultaneous push and pop when count is in 1..DEPTH-1: both take effect and count is unchanged.
- Full (count=DEPTH): if_full_n=0, so a write is blocked even if a pop occurs in the same cycle. There is no write-through-on-read.
- Empty (count=0): if_empty_n=0, so a read is ignored. A same-cycle push still lands; there is no bypass to if_dout in that cycle.
- Flag derivation:
  - if_empty_n = (count != 0)
  - if_full_n = (count != DEPTH)
  - if_almost_full_n = (count < DEPTH - ALMOST_FULL_MARGIN)
  - All three are registered and computed from the next-state count, so they are valid in the same cycle as the new count.
- if_dout = mem[rd_ptr], combinational from storage. Data is not cleared on reset.

## Timing
- Reset (reset=0 at a rising edge) sets:
  - rd_ptr=0, wr_ptr=0, if_count=0
  - if_empty_n=0, if_full_n=1
  - if_almost_full_n=1
- Reset wins over any same-cycle push or pop.
- Reset mid-operation discards all contents. Outputs take their reset values in the cycle after the edge.
- Write-to-read latency is 1 cycle: a word pushed at edge N makes if_empty_n=1, with that word on if_dout, after edge N.
- Pop-to-next-head: after the pop edge, if_dout shows the next word combinationally, or if_empty_n drops if that was the last word.
- Full-flag latency: the push that makes count=DEPTH drops if_full_n after the same edge. The pop from full raises it after the pop edge.
- if_almost_full_n follows the same 1-edge rule. With ALMOST_FULL_MARGIN=0 it is identical to if_full_n.
- if_write_ce=0 or if_read_ce=0 freezes that side completely, even when its request is high.
- Throughput: one push and one pop per cycle sustained at any count from 1 to DEPTH-1.

## Test plan
- Fill and drain: DATA_WIDTH=8, DEPTH=4, margin 1; push 0xA0..0xA3 on consecutive cycles.
  - Flags: if_almost_full_n drops after the 3rd push (count=3); if_full_n drops after the 4th (count=4).
  - Extra push: a 5th push of 0xA4 is ignored.
  - Drain: pops return A0, A1, A2, A3 in order; if_empty_n drops after the 4th pop.
- Streaming at half occupancy: DEPTH=4, count=2, push and pop every cycle for 20 cycles.
  - if_count stays at 2 throughout.
  - The output sequence equals the input sequence delayed by 2 words.
- Non-power-of-two wrap: DEPTH=5, ADDR_WIDTH=3; run 12 push-then-pop pairs with data 1..12.
  - Every value is read back in order.
  - if_count alternates 1 and 0.
- Full with simultaneous request: count=4 in the DEPTH=4 configuration; assert write(0x55) and read in the same cycle.
  - The head is popped; 0x55 is not stored.
  - if_count becomes 3 and if_full_n rises.
- Clock-enable gating: count=1 with head 0x11; hold if_read=1 and if_read_ce=0 for 3 cycles, then raise if_read_ce.
  - While if_read_ce=0: if_dout stays 0x11 and if_count stays 1.
  - After if_read_ce rises: the pop occurs on the next edge.
- Reset mid-stream: count=3; drive reset=0 for one edge while if_write=1.
  - After the edge: if_count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1.
  - The word offered on that edge is not stored.
